// File: rtl/csr_defs.sv
// Shared definitions for the LoongArch CSR file: addresses, field layout,
// writable-bit masks, exception codes and the masked-write merge helper.
package csr_defs;

    localparam logic [13:0] CSR_CRMD   = 14'h0000;
    localparam logic [13:0] CSR_PRMD   = 14'h0001;
    localparam logic [13:0] CSR_ECFG   = 14'h0004;
    localparam logic [13:0] CSR_ESTAT  = 14'h0005;
    localparam logic [13:0] CSR_ERA    = 14'h0006;
    localparam logic [13:0] CSR_BADV   = 14'h0007;
    localparam logic [13:0] CSR_EENTRY = 14'h000C;
    localparam logic [13:0] CSR_SAVE0  = 14'h0030;
    localparam logic [13:0] CSR_SAVE1  = 14'h0031;
    localparam logic [13:0] CSR_SAVE2  = 14'h0032;
    localparam logic [13:0] CSR_SAVE3  = 14'h0033;
    localparam logic [13:0] CSR_TID    = 14'h0040;
    localparam logic [13:0] CSR_TCFG   = 14'h0041;
    localparam logic [13:0] CSR_TVAL   = 14'h0042;
    localparam logic [13:0] CSR_TICLR  = 14'h0044;

    // Bits software may change through csr_we; everything else is hardware-owned or zero.
    localparam logic [31:0] WMASK_CRMD   = 32'h0000_01FF;
    localparam logic [31:0] WMASK_PRMD   = 32'h0000_0007;
    localparam logic [31:0] WMASK_ECFG   = 32'h0000_1BFF;
    localparam logic [31:0] WMASK_EENTRY = 32'hFFFF_FFC0;
    localparam logic [31:0] WMASK_FULL   = 32'hFFFF_FFFF;
    localparam logic [31:0] WMASK_TCFG   = 32'hFFFF_FFFF;

    localparam logic [31:0] CRMD_RESET   = 32'h0000_0008;
    localparam int          ESTAT_TI_BIT = 11;

    typedef enum logic [5:0] {
        ECODE_INT  = 6'h00,
        ECODE_ADEF = 6'h08,
        ECODE_ALE  = 6'h09,
        ECODE_SYS  = 6'h0B,
        ECODE_BRK  = 6'h0C,
        ECODE_INE  = 6'h0D
    } ecode_e;

    function automatic logic [31:0] csr_merge(
        input logic [31:0] old_value,
        input logic [31:0] wmask,
        input logic [31:0] wvalue,
        input logic [31:0] writable
    );
        logic [31:0] eff_mask;
        eff_mask = wmask & writable;
        return (old_value & ~eff_mask) | (wvalue & eff_mask);
    endfunction

endpackage

// File: rtl/csr_timer.sv
// Constant timer: holds TCFG, counts down from {InitVal,2'b00} and flags expiry
// while enabled at zero; one-shot mode parks at all-ones after wrapping.
module csr_timer
    import csr_defs::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_tcfg_we,
    input  logic [31:0] i_wmask,
    input  logic [31:0] i_wvalue,
    output logic [31:0] o_tcfg,
    output logic [31:0] o_tval,
    output logic        o_expire
);

    logic [31:0] r_tcfg;
    logic [31:0] r_cnt;
    logic [31:0] w_tcfg_new;
    logic [31:0] w_reload;
    logic        w_en;
    logic        w_periodic;

    assign w_tcfg_new = csr_merge(r_tcfg, i_wmask, i_wvalue, WMASK_TCFG);
    assign w_reload   = {r_tcfg[31:2], 2'b00};
    assign w_en       = r_tcfg[0];
    assign w_periodic = r_tcfg[1];

    // Configuration register and down-counter; a TCFG write beats a tick in the same cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tcfg <= 32'h0000_0000;
            r_cnt  <= 32'hFFFF_FFFF;
        end else if (i_tcfg_we) begin
            r_tcfg <= w_tcfg_new;
            r_cnt  <= {w_tcfg_new[31:2], 2'b00};
        end else if (w_en && (r_cnt != 32'hFFFF_FFFF)) begin
            if ((r_cnt == 32'h0000_0000) && w_periodic) begin
                r_cnt <= w_reload;
            end else begin
                r_cnt <= r_cnt - 32'h0000_0001;
            end
        end
    end

    assign o_tcfg   = r_tcfg;
    assign o_tval   = r_cnt;
    assign o_expire = w_en && (r_cnt == 32'h0000_0000);

endmodule

// File: rtl/csr_file.sv
// LoongArch control/status register file: software CSR access from WB,
// exception/ertn state updates, interrupt status collection and the timer.
module csr_file
    import csr_defs::*;
#(
    parameter logic [31:0] TID_INIT    = 32'h0000_0000,
    parameter logic [31:0] EENTRY_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_ex_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] era_out,
    output logic        has_int
);

    logic [31:0] r_crmd;
    logic [31:0] r_prmd;
    logic [31:0] r_ecfg;
    logic [31:0] r_estat;
    logic [31:0] r_era;
    logic [31:0] r_badv;
    logic [31:0] r_eentry;
    logic [31:0] r_save [0:3];
    logic [31:0] r_tid;

    logic        w_wr_en;
    logic        w_tcfg_we;
    logic        w_ticlr_clr;
    logic [31:0] w_tcfg;
    logic [31:0] w_tval;
    logic        w_timer_expire;
    logic [1:0]  w_is_lo;
    logic [5:0]  w_ecode;
    logic [8:0]  w_esubcode;
    logic        w_timer_flag;
    logic [31:0] w_estat_next;
    logic [31:0] w_rvalue;
    logic        w_unused_csr_re;

    // The read path is always live, so the read strobe carries no information here.
    assign w_unused_csr_re = csr_re;

    // A committing exception squashes the CSR write of the same instruction.
    assign w_wr_en     = csr_we && !wb_ex;
    assign w_tcfg_we   = w_wr_en && (csr_num == CSR_TCFG);
    assign w_ticlr_clr = w_wr_en && (csr_num == CSR_TICLR) && csr_wvalue[0] && csr_wmask[0];

    csr_timer u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .i_tcfg_we(w_tcfg_we),
        .i_wmask  (csr_wmask),
        .i_wvalue (csr_wvalue),
        .o_tcfg   (w_tcfg),
        .o_tval   (w_tval),
        .o_expire (w_timer_expire)
    );

    // Software writes, then exception/ertn side effects which take precedence.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_crmd   <= CRMD_RESET;
            r_prmd   <= 32'h0000_0000;
            r_ecfg   <= 32'h0000_0000;
            r_era    <= 32'h0000_0000;
            r_badv   <= 32'h0000_0000;
            r_eentry <= EENTRY_INIT;
            r_tid    <= TID_INIT;
            for (int i = 0; i < 4; i++) begin
                r_save[i] <= 32'h0000_0000;
            end
        end else begin
            if (w_wr_en) begin
                case (csr_num)
                    CSR_CRMD:   r_crmd    <= csr_merge(r_crmd,    csr_wmask, csr_wvalue, WMASK_CRMD);
                    CSR_PRMD:   r_prmd    <= csr_merge(r_prmd,    csr_wmask, csr_wvalue, WMASK_PRMD);
                    CSR_ECFG:   r_ecfg    <= csr_merge(r_ecfg,    csr_wmask, csr_wvalue, WMASK_ECFG);
                    CSR_ERA:    r_era     <= csr_merge(r_era,     csr_wmask, csr_wvalue, WMASK_FULL);
                    CSR_BADV:   r_badv    <= csr_merge(r_badv,    csr_wmask, csr_wvalue, WMASK_FULL);
                    CSR_EENTRY: r_eentry  <= csr_merge(r_eentry,  csr_wmask, csr_wvalue, WMASK_EENTRY);
                    CSR_SAVE0:  r_save[0] <= csr_merge(r_save[0], csr_wmask, csr_wvalue, WMASK_FULL);
                    CSR_SAVE1:  r_save[1] <= csr_merge(r_save[1], csr_wmask, csr_wvalue, WMASK_FULL);
                    CSR_SAVE2:  r_save[2] <= csr_merge(r_save[2], csr_wmask, csr_wvalue, WMASK_FULL);
                    CSR_SAVE3:  r_save[3] <= csr_merge(r_save[3], csr_wmask, csr_wvalue, WMASK_FULL);
                    CSR_TID:    r_tid     <= csr_merge(r_tid,     csr_wmask, csr_wvalue, WMASK_FULL);
                    default: ;
                endcase
            end
            if (wb_ex) begin
                r_prmd <= {r_prmd[31:3], r_crmd[2:0]};
                r_crmd <= {r_crmd[31:3], 3'b000};
                r_era  <= wb_ex_pc;
                if (wb_ecode == ECODE_ADEF) begin
                    r_badv <= wb_ex_pc;
                end else if (wb_ecode == ECODE_ALE) begin
                    r_badv <= wb_vaddr;
                end
            end else if (ertn_flush) begin
                r_crmd <= {r_crmd[31:3], r_prmd[2:0]};
            end
        end
    end

    // ESTAT next state: software IS[1:0], live interrupt lines, timer flag and exception cause.
    always_comb begin
        w_is_lo    = r_estat[1:0];
        w_ecode    = r_estat[21:16];
        w_esubcode = r_estat[30:22];
        if (w_wr_en && (csr_num == CSR_ESTAT)) begin
            w_is_lo = (r_estat[1:0] & ~csr_wmask[1:0]) | (csr_wvalue[1:0] & csr_wmask[1:0]);
        end else begin
            w_is_lo = r_estat[1:0];
        end
        if (wb_ex) begin
            w_ecode    = wb_ecode;
            w_esubcode = wb_esubcode;
        end else begin
            w_ecode    = r_estat[21:16];
            w_esubcode = r_estat[30:22];
        end
        // Expiry set beats a TICLR clear landing on the same edge.
        w_timer_flag = w_timer_expire || (r_estat[ESTAT_TI_BIT] && !w_ticlr_clr);
        w_estat_next = {1'b0, w_esubcode, w_ecode, 3'b000, ipi_int_in,
                        w_timer_flag, 1'b0, hw_int_in, w_is_lo};
    end

    // ESTAT register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_estat <= 32'h0000_0000;
        end else begin
            r_estat <= w_estat_next;
        end
    end

    // Zero-latency read mux; unimplemented addresses and TICLR read as zero.
    always_comb begin
        w_rvalue = 32'h0000_0000;
        case (csr_num)
            CSR_CRMD:   w_rvalue = r_crmd;
            CSR_PRMD:   w_rvalue = r_prmd;
            CSR_ECFG:   w_rvalue = r_ecfg;
            CSR_ESTAT:  w_rvalue = r_estat;
            CSR_ERA:    w_rvalue = r_era;
            CSR_BADV:   w_rvalue = r_badv;
            CSR_EENTRY: w_rvalue = r_eentry;
            CSR_SAVE0:  w_rvalue = r_save[0];
            CSR_SAVE1:  w_rvalue = r_save[1];
            CSR_SAVE2:  w_rvalue = r_save[2];
            CSR_SAVE3:  w_rvalue = r_save[3];
            CSR_TID:    w_rvalue = r_tid;
            CSR_TCFG:   w_rvalue = w_tcfg;
            CSR_TVAL:   w_rvalue = w_tval;
            CSR_TICLR:  w_rvalue = 32'h0000_0000;
            default:    w_rvalue = 32'h0000_0000;
        endcase
    end

    assign csr_rvalue = w_rvalue;
    assign ex_entry   = r_eentry;
    assign era_out    = r_era;
    assign has_int    = r_crmd[2] && (|(r_estat[12:0] & r_ecfg[12:0]));

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed walk through the main scenarios,
// then randomized traffic compared against a register-table reference model.
module tb_csr_file;

    localparam logic [31:0] P_TID    = 32'h5A5A_0001;
    localparam logic [31:0] P_EENTRY = 32'h1C00_8000;

    localparam logic [13:0] A_CRMD = 14'h00, A_PRMD = 14'h01, A_ECFG = 14'h04, A_ESTAT = 14'h05;
    localparam logic [13:0] A_ERA = 14'h06, A_BADV = 14'h07, A_EENTRY = 14'h0C;
    localparam logic [13:0] A_SAVE0 = 14'h30, A_SAVE1 = 14'h31, A_SAVE2 = 14'h32, A_SAVE3 = 14'h33;
    localparam logic [13:0] A_TID = 14'h40, A_TCFG = 14'h41, A_TVAL = 14'h42, A_TICLR = 14'h44;

    logic        clk = 1'b0;
    logic        resetn, csr_re, csr_we, wb_ex, ertn_flush, ipi_int_in, has_int;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue, csr_wmask, csr_wvalue, wb_ex_pc, wb_vaddr, ex_entry, era_out;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [7:0]  hw_int_in;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: plain registers in a table, ESTAT by field, timer as an integer count.
    logic [31:0] m_reg [logic [13:0]];
    logic [1:0]  m_islo;
    logic [5:0]  m_ecode;
    logic [8:0]  m_esub;
    logic [7:0]  m_hw;
    logic        m_ipi, m_ti;
    longint      m_cnt;

    csr_file #(.TID_INIT(P_TID), .EENTRY_INIT(P_EENTRY)) dut (
        .clk(clk), .resetn(resetn), .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_ex_pc(wb_ex_pc),
        .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .ex_entry(ex_entry), .era_out(era_out), .has_int(has_int)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] writable(input logic [13:0] a);
        case (a)
            A_CRMD:   return 32'h0000_01FF;
            A_PRMD:   return 32'h0000_0007;
            A_ECFG:   return 32'h0000_1BFF;
            A_EENTRY: return 32'hFFFF_FFC0;
            default:  return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [13:0] a);
        logic [31:0] c;
        if (a == A_ESTAT) return {1'b0, m_esub, m_ecode, 3'b000, m_ipi, m_ti, 1'b0, m_hw, m_islo};
        if (a == A_TVAL) begin
            c = m_cnt[31:0];
            return c;
        end
        if (m_reg.exists(a)) return m_reg[a];
        return 32'h0000_0000;
    endfunction

    function automatic logic m_has_int();
        logic [31:0] st, crmd, ecfg;
        st   = m_read(A_ESTAT);
        crmd = m_reg[A_CRMD];
        ecfg = m_reg[A_ECFG];
        return crmd[2] && (|(st[12:0] & ecfg[12:0]));
    endfunction

    task automatic model_reset();
        m_reg.delete();
        m_reg[A_CRMD] = 32'h8;  m_reg[A_PRMD] = 32'h0; m_reg[A_ECFG] = 32'h0;
        m_reg[A_ERA] = 32'h0;   m_reg[A_BADV] = 32'h0; m_reg[A_EENTRY] = P_EENTRY;
        m_reg[A_SAVE0] = 32'h0; m_reg[A_SAVE1] = 32'h0; m_reg[A_SAVE2] = 32'h0; m_reg[A_SAVE3] = 32'h0;
        m_reg[A_TID] = P_TID;   m_reg[A_TCFG] = 32'h0;
        m_islo = 2'b00; m_ecode = 6'h0; m_esub = 9'h0; m_hw = 8'h0; m_ipi = 1'b0; m_ti = 1'b0;
        m_cnt = -1;
    endtask

    // One clock edge of architectural behaviour, from the inputs currently driven.
    task automatic model_step();
        logic [31:0] crmd0, prmd0, tcfg0, wm, tn;
        longint      cnt0;
        logic        we, expire, clr;
        crmd0 = m_reg[A_CRMD]; prmd0 = m_reg[A_PRMD]; tcfg0 = m_reg[A_TCFG]; cnt0 = m_cnt;
        we     = csr_we && !wb_ex;
        expire = tcfg0[0] && (cnt0 == 0);
        clr    = we && (csr_num == A_TICLR) && csr_wvalue[0] && csr_wmask[0];
        if (we) begin
            wm = csr_wmask & writable(csr_num);
            if (m_reg.exists(csr_num)) m_reg[csr_num] = (m_reg[csr_num] & ~wm) | (csr_wvalue & wm);
            if (csr_num == A_ESTAT) m_islo = (m_islo & ~csr_wmask[1:0]) | (csr_wvalue[1:0] & csr_wmask[1:0]);
        end
        if (wb_ex) begin
            m_reg[A_PRMD] = (prmd0 & ~32'h7) | (crmd0 & 32'h7);
            m_reg[A_CRMD] = crmd0 & ~32'h7;
            m_reg[A_ERA]  = wb_ex_pc;
            m_ecode = wb_ecode;
            m_esub  = wb_esubcode;
            if (wb_ecode == 6'h08) m_reg[A_BADV] = wb_ex_pc;
            else if (wb_ecode == 6'h09) m_reg[A_BADV] = wb_vaddr;
        end else if (ertn_flush) begin
            m_reg[A_CRMD] = (crmd0 & ~32'h7) | (prmd0 & 32'h7);
        end
        m_hw  = hw_int_in;
        m_ipi = ipi_int_in;
        m_ti  = expire || (m_ti && !clr);
        if (we && (csr_num == A_TCFG)) begin
            tn = m_reg[A_TCFG];
            m_cnt = longint'(tn[31:2]) * 4;
        end else if (tcfg0[0] && (cnt0 != -1)) begin
            if ((cnt0 == 0) && tcfg0[1]) m_cnt = longint'(tcfg0[31:2]) * 4;
            else m_cnt = cnt0 - 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!resetn) model_reset();
        else model_step();
        #1;
    endtask

    task automatic rd(input logic [13:0] a, output logic [31:0] v);
        csr_num = a;
        #1;
        v = csr_rvalue;
    endtask

    task automatic check_rd(input string tag, input logic [13:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        check_eq(tag, v, exp);
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] m, input logic [31:0] v);
        csr_num = a; csr_wmask = m; csr_wvalue = v; csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic ertn();
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
    endtask

    logic [31:0] v;
    logic [13:0] addrs [0:17];
    logic [5:0]  codes [0:5];

    initial begin
        addrs = '{A_CRMD, A_PRMD, A_ECFG, A_ESTAT, A_ERA, A_BADV, A_EENTRY, A_SAVE0, A_SAVE1,
                  A_SAVE2, A_SAVE3, A_TID, A_TCFG, A_TVAL, A_TICLR, 14'h02, 14'h43, 14'h3FFF};
        codes = '{6'h00, 6'h08, 6'h09, 6'h0B, 6'h0C, 6'h0D};
        resetn = 1'b0; csr_re = 1'b1; csr_num = 14'h0; csr_we = 1'b0; csr_wmask = 32'h0;
        csr_wvalue = 32'h0; wb_ex = 1'b0; wb_ecode = 6'h0; wb_esubcode = 9'h0; wb_ex_pc = 32'h0;
        wb_vaddr = 32'h0; ertn_flush = 1'b0; hw_int_in = 8'h0; ipi_int_in = 1'b0;
        model_reset();
        repeat (2) tick();
        resetn = 1'b1;

        check_rd("crmd_reset", A_CRMD, 32'h0000_0008);
        check_rd("eentry_reset", A_EENTRY, P_EENTRY);
        check_rd("tid_reset", A_TID, P_TID);
        check_rd("tval_reset", A_TVAL, 32'hFFFF_FFFF);
        check_eq("ex_entry_reset", ex_entry, P_EENTRY);
        check_eq("era_out_reset", era_out, 32'h0);
        check_eq("has_int_reset", {31'b0, has_int}, 32'h0);

        wr(A_SAVE0, 32'hFFFF_FFFF, 32'hAAAA_AAAA);
        wr(A_SAVE0, 32'h0000_FFFF, 32'h1234_5678);
        check_rd("save0_masked", A_SAVE0, 32'hAAAA_5678);
        wr(A_ESTAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_rd("estat_sw_bits", A_ESTAT, 32'h0000_0003);
        wr(A_ESTAT, 32'h0000_0003, 32'h0);

        wr(A_CRMD, 32'hFFFF_FFFF, 32'h0000_0007);
        check_rd("crmd_write", A_CRMD, 32'h0000_0007);
        wb_ex = 1'b1; wb_ecode = 6'h0B; wb_esubcode = 9'h0; wb_ex_pc = 32'h1C00_0100;
        tick();
        wb_ex = 1'b0;
        check_rd("crmd_ex", A_CRMD, 32'h0);
        check_rd("prmd_ex", A_PRMD, 32'h7);
        check_rd("era_ex", A_ERA, 32'h1C00_0100);
        rd(A_ESTAT, v);
        check_eq("estat_ecode", {26'b0, v[21:16]}, 32'h0B);
        check_eq("era_out_ex", era_out, 32'h1C00_0100);
        ertn();
        check_rd("crmd_ertn", A_CRMD, 32'h7);

        csr_num = A_SAVE1; csr_we = 1'b1; csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'hDEAD_BEEF;
        wb_ex = 1'b1; wb_ecode = 6'h09; wb_ex_pc = 32'h1C00_0200; wb_vaddr = 32'h8000_0003;
        tick();
        csr_we = 1'b0; wb_ex = 1'b0;
        check_rd("badv_ale", A_BADV, 32'h8000_0003);
        check_rd("save1_squashed", A_SAVE1, 32'h0);
        ertn();
        check_rd("crmd_ertn2", A_CRMD, 32'h7);

        wr(A_ECFG, 32'hFFFF_FFFF, 32'h0000_0800);
        wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_0011);
        check_rd("oneshot_load", A_TVAL, 32'd16);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check_rd("oneshot_count", A_TVAL, 32'(16 - i));
        end
        check_eq("has_int_before_expiry", {31'b0, has_int}, 32'h0);
        tick();
        rd(A_ESTAT, v);
        check_eq("ti_set", {31'b0, v[11]}, 32'h1);
        check_rd("oneshot_parked", A_TVAL, 32'hFFFF_FFFF);
        check_eq("has_int_timer", {31'b0, has_int}, 32'h1);
        tick();
        check_rd("oneshot_stays", A_TVAL, 32'hFFFF_FFFF);
        wr(A_TICLR, 32'h1, 32'h1);
        rd(A_ESTAT, v);
        check_eq("ti_cleared", {31'b0, v[11]}, 32'h0);
        check_eq("has_int_cleared", {31'b0, has_int}, 32'h0);
        check_rd("ticlr_reads_zero", A_TICLR, 32'h0);

        wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_000B);
        check_rd("periodic_load", A_TVAL, 32'd8);
        for (int k = 1; k <= 27; k++) begin
            tick();
            check_rd("periodic_count", A_TVAL, 32'(8 - (k % 9)));
            if (k == 8 || k == 9) begin
                rd(A_ESTAT, v);
                check_eq("periodic_ti", {31'b0, v[11]}, (k == 9) ? 32'h1 : 32'h0);
            end
        end

        hw_int_in = 8'h05;
        tick();
        rd(A_ESTAT, v);
        check_eq("hw_int_sampled", {24'b0, v[9:2]}, 32'h05);
        resetn = 1'b0;
        tick();
        resetn = 1'b1; hw_int_in = 8'h00;
        check_rd("tval_midreset", A_TVAL, 32'hFFFF_FFFF);
        check_rd("estat_midreset", A_ESTAT, 32'h0);

        for (int n = 0; n < 600; n++) begin
            csr_we      = ($urandom % 10) < 4;
            csr_num     = addrs[$urandom_range(0, 17)];
            csr_wmask   = ($urandom % 2 == 0) ? 32'hFFFF_FFFF : $urandom;
            csr_wvalue  = $urandom;
            if (csr_num == A_TCFG) csr_wvalue = (32'($urandom_range(0, 6)) << 2) | ($urandom & 32'h3);
            wb_ex       = ($urandom % 20) == 0;
            wb_ecode    = codes[$urandom_range(0, 5)];
            wb_esubcode = 9'($urandom);
            wb_ex_pc    = $urandom;
            wb_vaddr    = $urandom;
            ertn_flush  = ($urandom % 20) == 0;
            if ($urandom % 8 == 0) hw_int_in = 8'($urandom);
            ipi_int_in  = ($urandom % 16) == 0;
            resetn      = ($urandom % 150) != 0;
            tick();
            resetn = 1'b1; csr_we = 1'b0; wb_ex = 1'b0; ertn_flush = 1'b0;
            check_eq("rnd_ex_entry", ex_entry, m_reg[A_EENTRY]);
            check_eq("rnd_era_out", era_out, m_reg[A_ERA]);
            check_eq("rnd_has_int", {31'b0, has_int}, {31'b0, m_has_int()});
            csr_num = addrs[$urandom_range(0, 17)];
            check_rd("rnd_read", csr_num, m_read(csr_num));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
